present_keyctl: RTL and testbench
=================================

# present_keyctl

PRESENT-80 key schedule and round controller that sits directly upstream of the 64-bit state register. It generates the register's start/active strobes and a per-round 64-bit round key, and sequences one full 31-round encryption per request. The final whitening key K32 is presented in the `FIN` cycle for the output XOR. The round datapath (addRoundKey/sBox/pLayer) between this block and the state register is outside this block.

## Interface
- `NROUNDS`, 31, number of round-function applications; fixed for PRESENT-80.
- `ck`  in  1  rising-edge clock
- `rn`  in  1  reset; synchronous, active-low
- `start`  in  1  encryption request; sampled in `IDLE` only
- `key`  in  80 `[0:79]`  cipher key; bit 0 = k79 (MSB); sampled with `start`
- `sta`  out  1  state-register load strobe (load plaintext)
- `act`  out  1  state-register advance strobe (take next state)
- `rkey`  out  64 `[0:63]`  current round key = key register bits `[0:63]` (k79..k16)
- `rnd`  out  5 `[0:4]`  round counter (bit 0 = MSB)
- `busy`  out  1  high in `LOAD`, `RUN` and `FIN`
- `done`  out  1  one-cycle pulse in `FIN`; `rkey` = K32 in that cycle

## Operation
- Key register `kr[0:79]`, index 0 = k79.
- Key update, applied in order to form the next `kr`:
  - rotate left by 61: new `kr[i]` = old `kr[(i+61) mod 80]`
  - `kr[0:3]` ← S(`kr[0:3]`)
  - `kr[60:64]` (k19..k15) ← `kr[60:64]` XOR `rnd`
- S-box (hex, input 0..F): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- FSM states and transitions:
  - `IDLE`: `busy`/`sta`/`act`/`done` = 0. If `start` = 1: `kr` ← `key`, `rnd` ← 1, go to `LOAD`.
  - `LOAD`: `sta` = 1. Go to `RUN`.
  - `RUN`: `act` = 1; `rkey` = K`rnd`. Each edge applies the key update with the current `rnd`, then `rnd` ← `rnd`+1. When `rnd` = 31 at the edge, go to `FIN`.
  - `FIN`: `done` = 1, `rkey` = K32. `rnd` is 0 here (5-bit wrap). Go to `IDLE`; `kr` holds its value.
- `start` in `LOAD`, `RUN` or `FIN` is ignored; there is no queuing.
- `start` is accepted in the cycle right after `FIN`; back-to-back encryptions take 34 cycles each.
- `sta` and `act` are never high together.
- `rkey` is a combinational function of `kr` only.

## Timing
- Reset (`rn` = 0 at a rising edge): state ← `IDLE`, `kr` ← 0, `rnd` ← 0. All outputs are then 0.
- Reset overrides `start` and aborts any run in progress, with no `done`.
- Taking the `start` edge as E0:
  - `sta` is high in the cycle after E0.
  - `act` is high for exactly 31 cycles after that.
  - `done` is high in the 33rd cycle after E0.
- All outputs are registered state or decodes of state; there are no combinational paths from `start` or `key`.

## Structure
- Package `present_pkg` holds:
  - the S-box constant
  - `NROUNDS`
  - the FSM state enum (`IDLE`, `LOAD`, `RUN`, `FIN`)
  - key width 80 and state width 64
- Sub-module `present_sbox`: 4-bit combinational S-box. The round datapath reuses it, 16 copies.

## Test plan
- Key = 0, `start` pulse: `sta` in cycle 1; `act` in cycles 2–32; in cycle 3 `rkey` = C000000000000000 (K2); `done` in cycle 33.
- Reference-model bench chaining the state register and round datapath, `rkey` XOR on `done`:
  - pt 0, key 0 → 5579C1387B228445
  - pt 0, key FFFF…FF → E72C46C0F5945049
  - pt FFFF…FF, key 0 → A112FFC72F68417B
  - pt FFFF…FF, key FFFF…FF → 3333DCD3213210D2
- `start` held high continuously: one run per 34 cycles; no extra `sta` during `RUN`.
- `rn` = 0 at `rnd` = 15 mid-`RUN`: next cycle all outputs 0, state `IDLE`, no `done`. A fresh `start` then produces correct ciphertext.
- Random keys (≥1000) vs. software key schedule: `rkey` matches K1..K32 in every `RUN`/`FIN` cycle; `rnd` in `RUN` steps 1..31.

Source files
------------

// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
// Module      : present_pkg
// Description : Shared constants, S-box table and FSM encoding for PRESENT-80.
// Revision    : 1.0 - initial release
// ============================================================================
package present_pkg;

    localparam int NROUNDS   = 31;
    localparam int c_key_w   = 80;
    localparam int c_state_w = 64;
    localparam int c_rnd_w   = 5;

    localparam logic [c_rnd_w-1:0] c_last_rnd = c_rnd_w'(NROUNDS);

    // Nibble n of this word is S(n); entry 0 sits in the least significant nibble.
    localparam logic [63:0] c_sbox = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return c_sbox[4*x +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/present_sbox.sv
`default_nettype none
// ============================================================================
// Module      : present_sbox
// Description : 4-bit combinational PRESENT S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] i_x,
    output logic [3:0] o_y
);

    always_comb begin
        o_y = sbox4(i_x);
    end

endmodule
`default_nettype wire

// File: rtl/present_keyctl.sv
`default_nettype none
// ============================================================================
// Module      : present_keyctl
// Description : PRESENT-80 key schedule and round sequencer feeding the
//               64-bit state register (load/advance strobes, round keys).
// Revision    : 1.0 - initial release
// ============================================================================
module present_keyctl
    import present_pkg::*;
(
    input  logic                   ck,
    input  logic                   rn,
    input  logic                   start,
    input  logic [0:c_key_w-1]     key,
    output logic                   sta,
    output logic                   act,
    output logic [0:c_state_w-1]   rkey,
    output logic [0:c_rnd_w-1]     rnd,
    output logic                   busy,
    output logic                   done
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [0:c_key_w-1]     r_kr;
    logic [0:c_key_w-1]     w_kr_nxt;
    logic [0:c_key_w-1]     w_rot;
    logic [0:c_key_w-1]     w_kr_upd;
    logic [0:c_rnd_w-1]     r_rnd;
    logic [0:c_rnd_w-1]     w_rnd_nxt;
    logic [3:0]             w_sb;

    // Index 0 is k79, so a left rotation by 61 brings k18..k0 to the top.
    assign w_rot = {r_kr[61:c_key_w-1], r_kr[0:60]};

    present_sbox u_sbox (
        .i_x (w_rot[0:3]),
        .o_y (w_sb)
    );

    assign w_kr_upd = {w_sb, w_rot[4:59], w_rot[60:64] ^ r_rnd, w_rot[65:c_key_w-1]};

    assign rkey = r_kr[0:c_state_w-1];
    assign rnd  = r_rnd;

    always_comb begin
        w_state_nxt = r_state;
        w_kr_nxt    = r_kr;
        w_rnd_nxt   = r_rnd;
        sta         = 1'b0;
        act         = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_kr_nxt    = key;
                    w_rnd_nxt   = c_rnd_w'(1);
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                sta         = 1'b1;
                busy        = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                act       = 1'b1;
                busy      = 1'b1;
                w_kr_nxt  = w_kr_upd;
                // The counter wraps to 0 on the last round, which FIN relies on.
                w_rnd_nxt = r_rnd + c_rnd_w'(1);
                if (r_rnd == c_last_rnd) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                done        = 1'b1;
                busy        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rn) begin
            r_state <= IDLE;
            r_kr    <= '0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kr    <= w_kr_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_present_keyctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_present_keyctl
// Description : Directed self-checking bench for present_keyctl with a
//               behavioural round datapath and key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_present_keyctl;

    logic        ck;
    logic        rn;
    logic        start;
    logic [0:79] key;
    logic        sta;
    logic        act;
    logic [0:63] rkey;
    logic [0:4]  rnd;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    present_keyctl dut (
        .ck    (ck),
        .rn    (rn),
        .start (start),
        .key   (key),
        .sta   (sta),
        .act   (act),
        .rkey  (rkey),
        .rnd   (rnd),
        .busy  (busy),
        .done  (done)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: sb = 4'hC;  4'h1: sb = 4'h5;  4'h2: sb = 4'h6;  4'h3: sb = 4'hB;
            4'h4: sb = 4'h9;  4'h5: sb = 4'h0;  4'h6: sb = 4'hA;  4'h7: sb = 4'hD;
            4'h8: sb = 4'h3;  4'h9: sb = 4'hE;  4'hA: sb = 4'hF;  4'hB: sb = 4'h8;
            4'hC: sb = 4'h4;  4'hD: sb = 4'h7;  4'hE: sb = 4'h1;  default: sb = 4'h2;
        endcase
    endfunction

    // Key schedule written with k79 as bit 79.
    function automatic logic [79:0] ks_next(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sb(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [63:0] round_f(input logic [63:0] s, input logic [63:0] k);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] p;
        x = s ^ k;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sb(x[4*i +: 4]);
        for (int i = 0; i < 63; i++) p[(16*i) % 63] = y[i];
        p[63] = y[63];
        return p;
    endfunction

    task automatic run_enc(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp_ct);
        logic [79:0] km;
        logic [63:0] st;
        logic [63:0] ct;
        @(negedge ck);
        start = 1'b1;
        key   = k;
        @(negedge ck);
        start = 1'b0;
        key   = '0;
        km    = k;
        st    = pt;
        check_eq("load_sta", 80'(sta), 80'd1);
        check_eq("load_act", 80'(act), 80'd0);
        check_eq("load_busy", 80'(busy), 80'd1);
        check_eq("load_rnd", 80'(rnd), 80'd1);
        check_eq("load_rkey", 80'(rkey), 80'(km[79:16]));
        for (int r = 1; r <= 31; r++) begin
            @(negedge ck);
            check_eq("run_act", 80'(act), 80'd1);
            check_eq("run_sta", 80'(sta), 80'd0);
            check_eq("run_done", 80'(done), 80'd0);
            check_eq("run_rnd", 80'(rnd), 80'(r));
            check_eq("run_rkey", 80'(rkey), 80'(km[79:16]));
            if (k == 80'd0 && r == 2) check_eq("k2_zero_key", 80'(rkey), 80'h0000_C000_0000_0000_0000);
            if (k == 80'd0 && r == 3) check_eq("k3_zero_key", 80'(rkey), 80'h0000_5000_1800_0000_0001);
            st = round_f(st, km[79:16]);
            km = ks_next(km, 5'(r));
        end
        @(negedge ck);
        check_eq("fin_done", 80'(done), 80'd1);
        check_eq("fin_act", 80'(act), 80'd0);
        check_eq("fin_rnd", 80'(rnd), 80'd0);
        check_eq("fin_rkey_k32", 80'(rkey), 80'(km[79:16]));
        ct = st ^ rkey;
        check_eq("ciphertext", 80'(ct), 80'(exp_ct));
        @(negedge ck);
        check_eq("idle_busy", 80'(busy), 80'd0);
        check_eq("idle_done", 80'(done), 80'd0);
        check_eq("idle_kr_hold", 80'(rkey), 80'(km[79:16]));
    endtask

    initial begin
        int n_sta;
        int n_done;
        int n_ovl;
        int first_sta;
        int gap;
        n_checks = 0;
        n_fail   = 0;

        // Reset held while start is asserted: reset must win.
        rn    = 1'b0;
        start = 1'b1;
        key   = '1;
        repeat (3) @(negedge ck);
        check_eq("rst_sta", 80'(sta), 80'd0);
        check_eq("rst_act", 80'(act), 80'd0);
        check_eq("rst_busy", 80'(busy), 80'd0);
        check_eq("rst_done", 80'(done), 80'd0);
        check_eq("rst_rnd", 80'(rnd), 80'd0);
        check_eq("rst_rkey", 80'(rkey), 80'd0);
        start = 1'b0;
        rn    = 1'b1;
        @(negedge ck);
        check_eq("post_rst_busy", 80'(busy), 80'd0);

        run_enc(64'h0, 80'h0, 64'h5579C1387B228445);
        run_enc(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
        run_enc({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
        run_enc({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);

        // Start held high: one run per 34 cycles.
        n_sta = 0; n_done = 0; n_ovl = 0; first_sta = 0; gap = 0;
        @(negedge ck);
        start = 1'b1;
        key   = '0;
        for (int i = 1; i <= 68; i++) begin
            @(negedge ck);
            if (sta && act) n_ovl++;
            if (done) n_done++;
            if (sta) begin
                n_sta++;
                if (n_sta == 1) first_sta = i;
                else gap = i - first_sta;
            end
        end
        start = 1'b0;
        check_eq("held_sta_count", 80'(n_sta), 80'd2);
        check_eq("held_done_count", 80'(n_done), 80'd2);
        check_eq("held_period", 80'(gap), 80'd34);
        check_eq("held_sta_act_overlap", 80'(n_ovl), 80'd0);

        // Abort mid-run with reset at round 15.
        @(negedge ck);
        start = 1'b1;
        key   = '0;
        @(negedge ck);
        start = 1'b0;
        repeat (15) @(negedge ck);
        check_eq("abort_rnd15", 80'(rnd), 80'd15);
        rn = 1'b0;
        @(negedge ck);
        rn = 1'b1;
        check_eq("abort_act", 80'(act), 80'd0);
        check_eq("abort_busy", 80'(busy), 80'd0);
        check_eq("abort_sta", 80'(sta), 80'd0);
        check_eq("abort_rnd", 80'(rnd), 80'd0);
        check_eq("abort_rkey", 80'(rkey), 80'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ck);
            if (done || busy) n_done++;
        end
        check_eq("abort_no_done", 80'(n_done), 80'd0);

        run_enc(64'h0, 80'h0, 64'h5579C1387B228445);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
